// File: rtl/ppi_branch_bank.sv
// ppi_branch_bank -- polyphase interpolator branch bank.
// Holds a K-deep delay line of input samples and, for every accepted
// sample, runs one multiply-accumulate per cycle over all L branches
// (K taps each) of an L*K-tap prototype filter. Each branch result is
// rounded half-up, reduced to DOUT_W bits and presented as one parallel
// L*DOUT_W word for the downstream commutator.
// Optional feature macro: PPI_BRANCH_SAT_EN -- when defined, branch results
// saturate to the signed DOUT_W range; otherwise they wrap (keep the LSBs).
module ppi_branch_bank #(
    parameter int L      = 4,
    parameter int K      = 4,
    parameter int DIN_W  = 4,
    parameter int COEF_W = 8,
    parameter int DOUT_W = 4,
    parameter int SHIFT  = 7,
    parameter logic [L*K*COEF_W-1:0] COEFS = {(L*K){COEF_W'(32'sd64)}}
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DIN_W-1:0]      i_data,
    output logic [L*DOUT_W-1:0]   o_data,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_ovf
);

    // Accumulator is wide enough for K full-scale products plus sign.
    localparam int ACC_W  = DIN_W + COEF_W + $clog2(K) + 1;
    localparam int PROD_W = DIN_W + COEF_W;
    localparam int P_W    = (L > 1) ? $clog2(L) : 1;
    localparam int K_W    = (K > 1) ? $clog2(K) : 1;

    localparam logic [P_W-1:0] P_LAST = P_W'(L - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(K - 1);
    localparam logic [P_W-1:0] P_ONE  = P_W'(1);
    localparam logic [K_W-1:0] K_ONE  = K_W'(1);

    // Rounding constant and saturation limits, carried one bit wider than
    // the accumulator so the half-LSB addition can never overflow.
    localparam logic signed [ACC_W:0] RND_C   = (ACC_W+1)'(32'sd1) <<< (SHIFT - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((32'sd1 <<< (DOUT_W - 1)) - 32'sd1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(32'sd1 <<< (DOUT_W - 1)));

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MAC  = 1'b1
    } state_t;

    // Round half-up (floor after adding half an output LSB), then fit the
    // result into DOUT_W bits either by saturation or by wrapping.
    function automatic logic [DOUT_W-1:0] round_fit(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] ext_v;
        logic signed [ACC_W:0] shf_v;
        logic [DOUT_W-1:0]     res_v;
        ext_v = {a[ACC_W-1], a} + RND_C;
        shf_v = ext_v >>> SHIFT;
`ifdef PPI_BRANCH_SAT_EN
        if (shf_v > SAT_MAX) begin
            res_v = SAT_MAX[DOUT_W-1:0];
        end else if (shf_v < SAT_MIN) begin
            res_v = SAT_MIN[DOUT_W-1:0];
        end else begin
            res_v = shf_v[DOUT_W-1:0];
        end
`else
        res_v = shf_v[DOUT_W-1:0];
`endif
        return res_v;
    endfunction

    state_t                    state_r;
    state_t                    state_s;
    logic signed [DIN_W-1:0]   x_r [K];
    logic signed [ACC_W-1:0]   acc_r;
    logic [P_W-1:0]            p_r;
    logic [K_W-1:0]            k_r;
    logic [DOUT_W-1:0]         slot_r [L];
    logic                      done_r;

    logic                      accept_s;
    logic                      drop_s;
    logic                      last_k_s;
    logic                      last_s;
    int                        coef_idx_s;
    logic signed [COEF_W-1:0]  coef_s;
    logic signed [DIN_W-1:0]   x_sel_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   acc_sum_s;
    logic [DOUT_W-1:0]         res_s;
    logic [L*DOUT_W-1:0]       pack_s;

    // Tap-position flags for the current MAC step.
    always_comb begin
        last_k_s = (k_r == K_LAST);
        last_s   = (k_r == K_LAST) && (p_r == P_LAST);
    end

    // Next-state and accept/drop decode for the IDLE/MAC sequencer.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        drop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_valid) begin
                    accept_s = 1'b1;
                    state_s  = ST_MAC;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (i_valid) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = 1'b0;
                end
                if (last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_MAC;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Coefficient fetch h[k*L+p], sample select x[k], product and running sum.
    always_comb begin
        coef_idx_s = (int'(k_r) * L) + int'(p_r);
        coef_s     = COEFS[coef_idx_s*COEF_W +: COEF_W];
        x_sel_s    = x_r[k_r];
        prod_s     = x_sel_s * coef_s;
        acc_sum_s  = acc_r + ACC_W'(prod_s);
        res_s      = round_fit(acc_sum_s);
    end

    // Pack completed branch slots into the parallel output word.
    always_comb begin
        pack_s = '0;
        for (int i = 0; i < L; i++) begin
            pack_s[i*DOUT_W +: DOUT_W] = slot_r[i];
        end
    end

    // Sequencer state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Delay line: shifts only when a sample is accepted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < K; i++) begin
                x_r[i] <= '0;
            end
        end else if (accept_s) begin
            x_r[0] <= i_data;
            for (int i = 1; i < K; i++) begin
                x_r[i] <= x_r[i-1];
            end
        end else begin
            for (int i = 0; i < K; i++) begin
                x_r[i] <= x_r[i];
            end
        end
    end

    // MAC datapath: accumulator, phase/tap counters and branch slot writes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_r <= '0;
            p_r   <= '0;
            k_r   <= '0;
            for (int i = 0; i < L; i++) begin
                slot_r[i] <= '0;
            end
        end else if (accept_s) begin
            acc_r <= '0;
            p_r   <= '0;
            k_r   <= '0;
        end else if (state_r == ST_MAC) begin
            if (last_k_s) begin
                slot_r[p_r] <= res_s;
                acc_r       <= '0;
                k_r         <= '0;
                p_r         <= last_s ? '0 : (p_r + P_ONE);
            end else begin
                acc_r <= acc_sum_s;
                k_r   <= k_r + K_ONE;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    // Output stage: publish slots one edge after the final product, with a
    // one-cycle strobe; busy covers acceptance through the strobe cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            done_r  <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_busy  <= 1'b0;
        end else begin
            done_r  <= (state_r == ST_MAC) && last_s;
            o_valid <= done_r;
            o_busy  <= accept_s || (state_r == ST_MAC) || done_r;
            if (done_r) begin
                o_data <= pack_s;
            end else begin
                o_data <= o_data;
            end
        end
    end

    // Sticky overrun flag: set when a sample arrives mid-sequence.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ovf <= 1'b0;
        end else if (drop_s) begin
            o_ovf <= 1'b1;
        end else begin
            o_ovf <= o_ovf;
        end
    end

endmodule

// File: tb/tb_ppi_branch_bank.sv
// Directed testbench for ppi_branch_bank: impulse, rounding, saturation/wrap,
// overrun, back-to-back and mid-sequence reset.
module tb_ppi_branch_bank;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [3:0]  din;
    logic [15:0] dout_a;
    logic        vld_a;
    logic        busy_a;
    logic        ovf_a;
    logic [15:0] dout_b;
    logic        vld_b;
    logic        busy_b;
    logic        ovf_b;

    int checks   = 0;
    int failures = 0;
    int vcount   = 0;
    int n        = 0;

    ppi_branch_bank dut_a (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .i_data  (din),
        .o_data  (dout_a),
        .o_valid (vld_a),
        .o_busy  (busy_a),
        .o_ovf   (ovf_a)
    );

    ppi_branch_bank #(.COEFS({16{8'h7F}})) dut_b (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .i_data  (din),
        .o_data  (dout_b),
        .o_valid (vld_b),
        .o_busy  (busy_b),
        .o_ovf   (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (vld_a === 1'b1) vcount++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send(input logic [3:0] v);
        din   = v;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        din   = 4'h0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (vld_a === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin
        rst   = 1'b0;
        valid = 1'b0;
        din   = 4'h0;
        #2;
        do_reset();

        // Reset state
        check("rst_data",  32'(dout_a), 32'h0);
        check("rst_valid", 32'(vld_a),  32'h0);
        check("rst_busy",  32'(busy_a), 32'h0);
        check("rst_ovf",   32'(ovf_a),  32'h0);

        // Impulse: 4*64 = 256 -> round(256/128) = 2 on every branch
        send(4'd4);
        check("imp_busy_start", 32'(busy_a), 32'h1);
        wait_valid(n);
        check("imp_latency", 32'(n), 32'd17);
        check("imp_data",    32'(dout_a), 32'h2222);
        check("imp_busy_ov", 32'(busy_a), 32'h1);
        tick();
        check("imp_valid_1cyc", 32'(vld_a),  32'h0);
        check("imp_busy_end",   32'(busy_a), 32'h0);
        tick(); tick(); tick();
        check("imp_hold", 32'(dout_a), 32'h2222);

        // Rounding: 3*64 = 192 -> (192+64)>>7 = 2
        do_reset();
        send(4'd3);
        wait_valid(n);
        check("rnd_pos", 32'(dout_a), 32'h2222);

        // Rounding: -8*64 = -512 -> (-448)>>>7 = -4 -> 4'hC
        do_reset();
        send(4'h8);
        wait_valid(n);
        check("rnd_neg", 32'(dout_a), 32'hCCCC);

        // Saturation / wrap: four spaced samples of 7
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(4'd7);
            wait_valid(n);
            tick();
        end
`ifdef PPI_BRANCH_SAT_EN
        check("sat_coef127", 32'(dout_b), 32'h7777);
        check("sat_coef64",  32'(dout_a), 32'h7777);
`else
        // 3556 -> 28 -> 4'hC ; 1792 -> 14 -> 4'hE
        check("wrap_coef127", 32'(dout_b), 32'hCCCC);
        check("wrap_coef64",  32'(dout_a), 32'hEEEE);
`endif

        // Overrun: second sample 5 edges after the first is dropped
        do_reset();
        send(4'd4);
        tick(); tick(); tick(); tick();
        send(4'd5);
        check("ovr_flag", 32'(ovf_a), 32'h1);
        wait_valid(n);
        check("ovr_latency", 32'(n), 32'd12);
        check("ovr_data",    32'(dout_a), 32'h2222);
        check("ovr_sticky",  32'(ovf_a), 32'h1);

        // Back-to-back at 17-cycle spacing: samples of 1, 4*64 -> 2
        do_reset();
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            send(4'd1);
            for (int j = 0; j < 16; j++) tick();
        end
        for (int j = 0; j < 20; j++) tick();
        check("b2b_pulses", 32'(vcount), 32'd4);
        check("b2b_ovf",    32'(ovf_a),  32'h0);
        check("b2b_data",   32'(dout_a), 32'h2222);

        // Mid-sequence reset: outputs clear at once, no strobe afterwards
        send(4'd4);
        for (int j = 0; j < 8; j++) tick();
        rst = 1'b1;
        #1;
        check("mrst_data",  32'(dout_a), 32'h0);
        check("mrst_valid", 32'(vld_a),  32'h0);
        check("mrst_busy",  32'(busy_a), 32'h0);
        check("mrst_ovf",   32'(ovf_a),  32'h0);
        tick();
        rst = 1'b0;
        vcount = 0;
        for (int j = 0; j < 30; j++) tick();
        check("mrst_no_pulse", 32'(vcount), 32'd0);
        check("mrst_idle",     32'(busy_a), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ppi_branch_bank.md
PPI_BRANCH_BANK -- requirements
Module: ppi_branch_bank

Interface
REQ-001 SHALL have parameter L, default 4, meaning interpolation factor and number of polyphase branches.
REQ-002 SHALL have parameter K, default 4, meaning taps per branch; the prototype filter has L*K taps.
REQ-003 SHALL have parameter DIN_W, default 4, meaning signed input sample width.
REQ-004 SHALL have parameter COEF_W, default 8, meaning signed coefficient width.
REQ-005 SHALL have parameter DOUT_W, default 4, meaning signed per-branch output width.
REQ-006 SHALL have parameter SHIFT, default 7, meaning number of accumulator LSBs dropped before output.
REQ-007 SHALL have parameter COEFS, default all taps = 64, meaning packed prototype taps, with tap n at [n*COEF_W +: COEF_W].
REQ-008 SHALL have port i_clk, input, 1 bit, meaning the single clock; all logic is rising-edge on it.
REQ-009 SHALL have port i_rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-010 SHALL have port i_valid, input, 1 bit, meaning i_data carries a new sample this cycle.
REQ-011 SHALL have port i_data, input, DIN_W bits, meaning signed input sample.
REQ-012 SHALL have port o_data, output, L*DOUT_W bits, meaning branch p result at [p*DOUT_W +: DOUT_W]; this feeds the commutator's parallel input.
REQ-013 SHALL have port o_valid, output, 1 bit, meaning a one-cycle strobe marking a new o_data word.
REQ-014 SHALL have port o_busy, output, 1 bit, meaning the MAC sequence is in progress.
REQ-015 SHALL have port o_ovf, output, 1 bit, meaning a sticky flag that a sample was dropped.

Function
REQ-016 SHALL hold a K-entry delay line x[0..K-1], with x[0] the newest sample, shifted only on an accepted i_valid.
REQ-017 SHALL implement a FSM with states IDLE and MAC; in IDLE, i_valid=1 shifts in i_data, clears the accumulator, zeroes the phase and tap counters (p, k) and moves to MAC.
REQ-018 SHALL in MAC perform one product per cycle, acc += x[k]*h[k*L+p], with k incrementing 0..K-1 inside p 0..L-1, for L*K cycles in total.
REQ-019 SHALL on completing k=K-1 write round(acc>>SHIFT) into output slot p, clear acc, and increment p.
REQ-020 SHALL round half-up: add 2^(SHIFT-1) before an arithmetic right shift, with floor toward minus infinity.
REQ-021 SHALL size the accumulator at DIN_W+COEF_W+clog2(K)+1 bits so that no internal overflow is possible.
REQ-022 SHALL update o_data from the completed slot register and pulse o_valid for exactly one cycle, L*K+1 clock edges after the edge that sampled i_valid, then return to IDLE.
REQ-023 SHALL hold o_data stable between o_valid pulses.
REQ-024 SHALL drive o_busy high from the cycle after acceptance until the o_valid cycle, inclusive.
REQ-025 SHALL ignore i_valid while busy: the sample is dropped, the delay line is unchanged, and o_ovf is set to 1 until reset.
REQ-026 SHALL accept i_valid in the cycle immediately following the o_valid cycle; the minimum input spacing is L*K+1 cycles.

Reset
REQ-027 SHALL on i_rst=1 immediately clear the delay line, accumulator, counters, slot registers, o_data (0), o_valid (0), o_busy (0) and o_ovf (0), and enter IDLE.
REQ-028 SHALL on reset asserted mid-MAC discard the partial result, so that no o_valid pulse follows reset release without a new i_valid.

Configuration
REQ-029 SHALL, when macro PPI_BRANCH_SAT_EN is defined, saturate each rounded branch result to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
REQ-030 SHALL, when PPI_BRANCH_SAT_EN is undefined, wrap each rounded branch result by keeping its DOUT_W LSBs.

Verification
REQ-031 SHALL be verified with an impulse: defaults, reset, i_data=4 then zeros -> o_data='h2222 with o_valid exactly 17 cycles after i_valid.
REQ-032 SHALL be verified for rounding: i_data=3 after reset (acc=192) -> o_data='h2222; i_data=-8 (acc=-512) -> o_data='hCCCC.
REQ-033 SHALL be verified for saturation: all COEFS=127, four spaced samples of 7 (acc=3556) -> o_data='h7777 with the macro defined, 'hCCCC without it.
REQ-034 SHALL be verified for overrun: a second i_valid 5 cycles after the first -> o_ovf=1, and the first result is unaffected.
REQ-035 SHALL be verified for mid-operation reset: i_rst pulsed 8 cycles into MAC -> all outputs 0 and no o_valid pulse.
REQ-036 SHALL be verified back-to-back: i_valid every 17 cycles, 4 samples -> 4 o_valid pulses and o_ovf=0.
